// File: rtl/btn_event_gen_if.sv
// Button event bus: raw pins and repeat enables in, debounced level and
// event strobes out.
//   master : drives i_btn / i_repeat_en, observes the outputs (integrator / bench)
//   slave  : the btn_event_gen block
interface btn_event_gen_if #(
    parameter int unsigned N_CH = 5
);
    logic [N_CH-1:0] i_btn;         // raw asynchronous button pins
    logic [N_CH-1:0] i_repeat_en;   // per-channel auto-repeat enable
    logic [N_CH-1:0] o_level;       // debounced level, 1 = pressed
    logic [N_CH-1:0] o_press_stb;   // one-cycle pulse on accepted press
    logic [N_CH-1:0] o_release_stb; // one-cycle pulse on accepted release
    logic [N_CH-1:0] o_long_stb;    // one-cycle pulse at long-press threshold
    logic [N_CH-1:0] o_repeat_stb;  // one-cycle auto-repeat pulse
    logic            o_any_stb;     // OR of press, long and repeat strobes

    modport master (
        output i_btn, i_repeat_en,
        input  o_level, o_press_stb, o_release_stb, o_long_stb, o_repeat_stb, o_any_stb
    );

    modport slave (
        input  i_btn, i_repeat_en,
        output o_level, o_press_stb, o_release_stb, o_long_stb, o_repeat_stb, o_any_stb
    );
endinterface

// File: rtl/btn_event_gen.sv
// Multi-channel button debouncer and event generator.
// Each channel: 2-flop synchronizer, polarity normalisation, stable-count
// debounce, then a RELEASED/PRESSED/HELD FSM producing long-press and
// auto-repeat strobes. All outputs are registered.
//   i_clk   : single clock, rising edge
//   i_rst_n : asynchronous active-low reset (deassertion synchronous to i_clk)
//   bus     : btn_event_gen_if slave (pins/enables in, level/strobes out)
module btn_event_gen #(
    parameter int unsigned N_CH          = 5,
    parameter int unsigned DB_CYCLES     = 16,
    parameter int unsigned LONG_CYCLES   = 1000,
    parameter int unsigned REPEAT_CYCLES = 250,
    parameter bit          ACTIVE_HIGH   = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    btn_event_gen_if.slave bus
);

    localparam int unsigned DB_W     = $clog2(DB_CYCLES + 1);
    localparam int unsigned HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);
    // Synchronizers come out of reset at the idle pin level so an idle
    // button produces no event on reset release.
    localparam logic [N_CH-1:0] IDLE_PIN = ACTIVE_HIGH ? '0 : '1;

    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_PRESSED  = 2'd1,
        ST_HELD     = 2'd2
    } state_e;

    logic [N_CH-1:0]   sync1_q, sync1_d;
    logic [N_CH-1:0]   sync2_q, sync2_d;
    logic [N_CH-1:0]   btn_n;
    logic [DB_W-1:0]   db_cnt_q [N_CH];
    logic [DB_W-1:0]   db_cnt_d [N_CH];
    logic [HOLD_W-1:0] hold_q   [N_CH];
    logic [HOLD_W-1:0] hold_d   [N_CH];
    state_e            state_q  [N_CH];
    state_e            state_d  [N_CH];
    logic [N_CH-1:0]   level_q, level_d;
    logic [N_CH-1:0]   press_q, press_d;
    logic [N_CH-1:0]   release_q, release_d;
    logic [N_CH-1:0]   long_q, long_d;
    logic [N_CH-1:0]   repeat_q, repeat_d;
    logic              any_q, any_d;

    // State registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q   <= IDLE_PIN;
            sync2_q   <= IDLE_PIN;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            repeat_q  <= '0;
            any_q     <= 1'b0;
            for (int i = 0; i < int'(N_CH); i++) begin
                db_cnt_q[i] <= '0;
                hold_q[i]   <= '0;
                state_q[i]  <= ST_RELEASED;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            any_q     <= any_d;
            db_cnt_q  <= db_cnt_d;
            hold_q    <= hold_d;
            state_q   <= state_d;
        end
    end

    // Debounce and per-channel event FSM next-state logic
    always_comb begin
        sync1_d   = bus.i_btn;
        sync2_d   = sync1_q;
        btn_n     = ACTIVE_HIGH ? sync2_q : ~sync2_q;
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        long_d    = '0;
        repeat_d  = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            db_cnt_d[i] = '0;
            hold_d[i]   = hold_q[i];
            state_d[i]  = state_q[i];

            // Count consecutive cycles the input disagrees with the level;
            // the DB_CYCLES-th such cycle flips the level.
            if (btn_n[i] != level_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
                    level_d[i]   = btn_n[i];
                    press_d[i]   = btn_n[i];
                    release_d[i] = ~btn_n[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end

            // A release overrides any long/repeat event due this cycle.
            if (release_d[i]) begin
                state_d[i] = ST_RELEASED;
                hold_d[i]  = '0;
            end else begin
                case (state_q[i])
                    ST_RELEASED: begin
                        if (press_d[i]) begin
                            state_d[i] = ST_PRESSED;
                            hold_d[i]  = '0;
                        end
                    end
                    ST_PRESSED: begin
                        if (hold_q[i] == HOLD_W'(LONG_CYCLES - 1)) begin
                            long_d[i]  = 1'b1;
                            hold_d[i]  = '0;
                            state_d[i] = ST_HELD;
                        end else begin
                            hold_d[i] = hold_q[i] + HOLD_W'(1);
                        end
                    end
                    ST_HELD: begin
                        // Disabled repeat parks the counter so re-enable
                        // starts a full period.
                        if (!bus.i_repeat_en[i]) begin
                            hold_d[i] = '0;
                        end else if (hold_q[i] == HOLD_W'(REPEAT_CYCLES - 1)) begin
                            repeat_d[i] = 1'b1;
                            hold_d[i]   = '0;
                        end else begin
                            hold_d[i] = hold_q[i] + HOLD_W'(1);
                        end
                    end
                    default: begin
                        state_d[i] = ST_RELEASED;
                        hold_d[i]  = '0;
                    end
                endcase
            end
        end
        any_d = |{press_d, long_d, repeat_d};
    end

    assign bus.o_level       = level_q;
    assign bus.o_press_stb   = press_q;
    assign bus.o_release_stb = release_q;
    assign bus.o_long_stb    = long_q;
    assign bus.o_repeat_stb  = repeat_q;
    assign bus.o_any_stb     = any_q;

endmodule

// File: tb/tb_btn_event_gen.sv
// Bench for btn_event_gen: one active-high 5-channel instance and one
// active-low 3-channel instance, compared every cycle against a
// timestamp-based model, plus directed latency/count expectations.
module tb_btn_event_gen;

    localparam int DB = 16;
    localparam int LG = 1000;
    localparam int RP = 250;
    localparam int NA = 5;
    localparam int NB = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    btn_event_gen_if #(.N_CH(NA)) bus_a ();
    btn_event_gen_if #(.N_CH(NB)) bus_b ();

    btn_event_gen #(.N_CH(NA), .DB_CYCLES(DB), .LONG_CYCLES(LG), .REPEAT_CYCLES(RP), .ACTIVE_HIGH(1'b1))
        dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_a));
    btn_event_gen #(.N_CH(NB), .DB_CYCLES(DB), .LONG_CYCLES(LG), .REPEAT_CYCLES(RP), .ACTIVE_HIGH(1'b0))
        dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_b));

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Rising-edge counter used for directed latency checks
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Level flips once the synchronized (2-edge delayed) pressed-value has
    // held the opposite value for DB consecutive edges. Long/repeat events
    // are derived from edge timestamps of the press and of the last
    // long/repeat/disabled cycle.
    logic       m_s1   [2][5];
    logic       m_s2   [2][5];
    logic       m_lvl  [2][5];
    logic       m_lastv[2][5];
    int         m_run  [2][5];
    int         m_mode [2][5];   // 0 released, 1 pressed, 2 held
    int         m_tp   [2][5];
    int         m_anc  [2][5];
    int         m_t;
    logic [4:0] e_lvl[2], e_prs[2], e_rel[2], e_lng[2], e_rep[2];
    logic       e_any[2];

    task automatic model_reset();
        m_t = 0;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 5; c++) begin
                m_s1[k][c] = (k == 0) ? 1'b0 : 1'b1;
                m_s2[k][c] = (k == 0) ? 1'b0 : 1'b1;
                m_lvl[k][c] = 1'b0; m_lastv[k][c] = 1'b0;
                m_run[k][c] = 0; m_mode[k][c] = 0; m_tp[k][c] = 0; m_anc[k][c] = 0;
            end
            e_lvl[k] = '0; e_prs[k] = '0; e_rel[k] = '0; e_lng[k] = '0; e_rep[k] = '0;
            e_any[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input logic [4:0] pin, input logic [4:0] en);
        logic v, rise, fall;
        int nch;
        nch = (k == 0) ? NA : NB;
        e_prs[k] = '0; e_rel[k] = '0; e_lng[k] = '0; e_rep[k] = '0;
        for (int c = 0; c < nch; c++) begin
            v = (k == 0) ? m_s2[k][c] : !m_s2[k][c];
            if (v == m_lastv[k][c]) m_run[k][c]++;
            else begin m_run[k][c] = 1; m_lastv[k][c] = v; end
            rise = 1'b0; fall = 1'b0;
            if (v != m_lvl[k][c] && m_run[k][c] == DB) begin
                m_lvl[k][c] = v; rise = v; fall = !v;
            end
            if (fall) m_mode[k][c] = 0;
            else if (rise) begin m_mode[k][c] = 1; m_tp[k][c] = m_t; end
            else if (m_mode[k][c] == 1 && m_t - m_tp[k][c] == LG) begin
                e_lng[k][c] = 1'b1; m_mode[k][c] = 2; m_anc[k][c] = m_t;
            end else if (m_mode[k][c] == 2) begin
                if (!en[c]) m_anc[k][c] = m_t;
                else if (m_t - m_anc[k][c] == RP) begin e_rep[k][c] = 1'b1; m_anc[k][c] = m_t; end
            end
            e_lvl[k][c] = m_lvl[k][c];
            e_prs[k][c] = rise;
            e_rel[k][c] = fall;
            m_s2[k][c] = m_s1[k][c];
            m_s1[k][c] = pin[c];
        end
        e_any[k] = |{e_prs[k], e_lng[k], e_rep[k]};
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else begin
                m_t++;
                model_step(0, 5'(bus_a.i_btn), 5'(bus_a.i_repeat_en));
                model_step(1, 5'(bus_b.i_btn), 5'(bus_b.i_repeat_en));
            end
        end
    end

    // Per-cycle compare of both instances against the model
    initial forever begin
        @(negedge clk);
        chk("a_level",   int'(bus_a.o_level),       int'(e_lvl[0]));
        chk("a_press",   int'(bus_a.o_press_stb),   int'(e_prs[0]));
        chk("a_release", int'(bus_a.o_release_stb), int'(e_rel[0]));
        chk("a_long",    int'(bus_a.o_long_stb),    int'(e_lng[0]));
        chk("a_repeat",  int'(bus_a.o_repeat_stb),  int'(e_rep[0]));
        chk("a_any",     int'(bus_a.o_any_stb),     int'(e_any[0]));
        chk("b_level",   int'(bus_b.o_level),       int'(e_lvl[1]));
        chk("b_press",   int'(bus_b.o_press_stb),   int'(e_prs[1]));
        chk("b_release", int'(bus_b.o_release_stb), int'(e_rel[1]));
        chk("b_long",    int'(bus_b.o_long_stb),    int'(e_lng[1]));
        chk("b_repeat",  int'(bus_b.o_repeat_stb),  int'(e_rep[1]));
        chk("b_any",     int'(bus_b.o_any_stb),     int'(e_any[1]));
    end

    // ---------------- event monitor for directed checks ----------------
    int a_prs_t[5], a_prs_n[5], a_rel_t[5], a_rel_n[5], a_lng_t[5], a_rep_n[5];
    int a_rep_t[5][4];
    int a_strb_n[5];
    bit a_lvl_hi[5];
    int b_all_t, b_prs_n, b_any_n;

    task automatic mon_clear();
        for (int c = 0; c < 5; c++) begin
            a_prs_t[c] = -1; a_prs_n[c] = 0; a_rel_t[c] = -1; a_rel_n[c] = 0;
            a_lng_t[c] = -1; a_rep_n[c] = 0; a_strb_n[c] = 0; a_lvl_hi[c] = 1'b0;
            for (int j = 0; j < 4; j++) a_rep_t[c][j] = -1;
        end
        b_all_t = -1; b_prs_n = 0; b_any_n = 0;
    endtask

    initial forever begin
        @(negedge clk);
        for (int c = 0; c < NA; c++) begin
            if (bus_a.o_press_stb[c])   begin a_prs_t[c] = cyc; a_prs_n[c]++; a_strb_n[c]++; end
            if (bus_a.o_release_stb[c]) begin a_rel_t[c] = cyc; a_rel_n[c]++; a_strb_n[c]++; end
            if (bus_a.o_long_stb[c])    begin a_lng_t[c] = cyc; a_strb_n[c]++; end
            if (bus_a.o_repeat_stb[c]) begin
                if (a_rep_n[c] < 4) a_rep_t[c][a_rep_n[c]] = cyc;
                a_rep_n[c]++; a_strb_n[c]++;
            end
            if (bus_a.o_level[c]) a_lvl_hi[c] = 1'b1;
        end
        if (bus_b.o_press_stb == 3'b111) b_all_t = cyc;
        if (|bus_b.o_press_stb) b_prs_n++;
        if (bus_b.o_any_stb) b_any_n++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // ---------------- stimulus ----------------
    logic [4:0] tgt[2], pins[2];
    int         rem[2][5], bnc[2][5];
    int         t0, t1;

    initial begin
        rst_n = 1'b0;
        bus_a.i_btn = '0; bus_a.i_repeat_en = '0;
        bus_b.i_btn = '1; bus_b.i_repeat_en = '0;
        mon_clear();
        step(3);
        rst_n = 1'b1;
        chk("reset_a_level", int'(bus_a.o_level), 0);
        chk("reset_a_any",   int'(bus_a.o_any_stb), 0);
        chk("reset_b_level", int'(bus_b.o_level), 0);
        step(30);
        chk("idle_no_event_b", b_prs_n, 0);

        // ch0 clean press and release
        mon_clear();
        bus_a.i_btn[0] = 1'b1; t0 = cyc;
        step(60);
        chk("ch0_press_latency", a_prs_t[0] - t0, 18);
        chk("ch0_press_width",   a_prs_n[0], 1);
        chk("ch0_level_high",    int'(bus_a.o_level[0]), 1);
        bus_a.i_btn[0] = 1'b0; t0 = cyc;
        step(60);
        chk("ch0_release_latency", a_rel_t[0] - t0, 18);
        chk("ch0_release_width",   a_rel_n[0], 1);
        chk("ch0_level_low",       int'(bus_a.o_level[0]), 0);

        // ch1 15-cycle glitch is rejected
        mon_clear();
        bus_a.i_btn[1] = 1'b1;
        step(15);
        bus_a.i_btn[1] = 1'b0;
        step(60);
        chk("ch1_glitch_strobes", a_strb_n[1], 0);
        chk("ch1_glitch_level",   int'(a_lvl_hi[1]), 0);

        // ch2 held 1600 cycles with repeat enabled
        mon_clear();
        bus_a.i_repeat_en[2] = 1'b1;
        bus_a.i_btn[2] = 1'b1; t0 = cyc;
        step(1600);
        bus_a.i_btn[2] = 1'b0; t1 = cyc;
        step(60);
        chk("ch2_press_latency", a_prs_t[2] - t0, 18);
        chk("ch2_long_delay",    a_lng_t[2] - a_prs_t[2], 1000);
        chk("ch2_repeat1",       a_rep_t[2][0] - a_lng_t[2], 250);
        chk("ch2_repeat2",       a_rep_t[2][1] - a_lng_t[2], 500);
        chk("ch2_repeat_count",  a_rep_n[2], 2);
        chk("ch2_release_latency", a_rel_t[2] - t1, 18);

        // active-low instance: all pins pressed together
        mon_clear();
        bus_b.i_btn = '0; t0 = cyc;
        step(60);
        chk("b_all_press_latency", b_all_t - t0, 18);
        chk("b_press_cycles",      b_prs_n, 1);
        chk("b_any_cycles",        b_any_n, 1);
        bus_b.i_btn = '1;
        step(60);

        // ch3 reset while HELD, button kept pressed through reset
        mon_clear();
        bus_a.i_btn[3] = 1'b1; t0 = cyc;
        step(1100);
        chk("ch3_long_before_reset", a_lng_t[3] - t0, 1018);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_level",  int'(bus_a.o_level), 0);
        chk("async_rst_strobe", int'(bus_a.o_press_stb | bus_a.o_release_stb |
                                     bus_a.o_long_stb | bus_a.o_repeat_stb), 0);
        chk("async_rst_any",    int'(bus_a.o_any_stb), 0);
        step(2);
        rst_n = 1'b1;
        mon_clear(); t0 = cyc;
        step(1100);
        chk("ch3_repress_latency", a_prs_t[3] - t0, 18);
        chk("ch3_relong_delay",    a_lng_t[3] - a_prs_t[3], 1000);
        bus_a.i_btn[3] = 1'b0;
        step(60);

        // randomized bouncing pins and repeat enables on both instances
        tgt[0] = '0; tgt[1] = '1;
        pins[0] = '0; pins[1] = '1;
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < 5; c++) begin
                rem[k][c] = $urandom_range(400, 1);
                bnc[k][c] = 0;
            end
        for (int n = 0; n < 20000; n++) begin
            step(1);
            for (int k = 0; k < 2; k++) begin
                for (int c = 0; c < ((k == 0) ? NA : NB); c++) begin
                    if (rem[k][c] == 0) begin
                        tgt[k][c] = ~tgt[k][c];
                        rem[k][c] = $urandom_range(1800, 3);
                        bnc[k][c] = $urandom_range(12, 0);
                    end else begin
                        rem[k][c]--;
                    end
                    if (bnc[k][c] > 0) begin
                        pins[k][c] = 1'($urandom % 2);
                        bnc[k][c]--;
                    end else begin
                        pins[k][c] = tgt[k][c];
                    end
                end
            end
            if ($urandom_range(299, 0) == 0) bus_a.i_repeat_en = 5'($urandom);
            if ($urandom_range(299, 0) == 0) bus_b.i_repeat_en = 3'($urandom);
            bus_a.i_btn = pins[0];
            bus_b.i_btn = 3'(pins[1]);
        end
        step(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/btn_event_gen.md
BTN_EVENT_GEN -- requirements
Module: btn_event_gen

Interface
REQ-001 SHALL have parameter N_CH, default 5, number of independent button channels (1..32).
REQ-002 SHALL have parameter DB_CYCLES, default 16, consecutive stable cycles required to accept a level change (>=2).
REQ-003 SHALL have parameter LONG_CYCLES, default 1000, cycles from press acceptance to long-press event (> DB_CYCLES).
REQ-004 SHALL have parameter REPEAT_CYCLES, default 250, auto-repeat period while held (>=2).
REQ-005 SHALL have parameter ACTIVE_HIGH, default 1; 1 = pressed reads 1, 0 = pressed reads 0.
REQ-006 SHALL have port i_clk  input  1  single clock; all state on rising edge.
REQ-007 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port i_btn  input  N_CH  raw asynchronous button pins.
REQ-009 SHALL have port i_repeat_en  input  N_CH  per-channel auto-repeat enable, sampled each cycle.
REQ-010 SHALL have port o_level  output  N_CH  debounced level, 1 = pressed regardless of ACTIVE_HIGH.
REQ-011 SHALL have port o_press_stb  output  N_CH  one-cycle pulse on accepted press.
REQ-012 SHALL have port o_release_stb  output  N_CH  one-cycle pulse on accepted release.
REQ-013 SHALL have port o_long_stb  output  N_CH  one-cycle pulse on long-press threshold.
REQ-014 SHALL have port o_repeat_stb  output  N_CH  one-cycle auto-repeat pulse.
REQ-015 SHALL have port o_any_stb  output  1  OR of all press, long and repeat strobes, same cycle.

Function
REQ-016 SHALL pass each i_btn bit through a two-flop synchronizer, then normalise polarity so 1 = pressed.
REQ-017 SHALL keep per-channel debounce counter of width $clog2(DB_CYCLES+1); cleared in any cycle the synchronized value equals o_level, incremented otherwise.
REQ-018 SHALL toggle o_level on the edge where the counter would reach DB_CYCLES, clearing the counter; glitches shorter than DB_CYCLES cycles produce no output change.
REQ-019 SHALL give latency of exactly DB_CYCLES+2 rising edges from first edge sampling a clean new pin level to o_level change.
REQ-020 SHALL assert o_press_stb / o_release_stb in the same cycle o_level rises / falls, registered, for exactly one cycle.
REQ-021 SHALL run per-channel FSM: RELEASED, PRESSED, HELD; reset state RELEASED.
REQ-022 SHALL transition RELEASED->PRESSED on accepted press, clearing hold counter (width $clog2(max(LONG_CYCLES,REPEAT_CYCLES)+1)).
REQ-023 SHALL in PRESSED increment hold counter each cycle; on the LONG_CYCLES-th edge after o_press_stb, pulse o_long_stb, clear counter, go HELD.
REQ-024 SHALL in HELD with i_repeat_en=1 pulse o_repeat_stb every REPEAT_CYCLES cycles, first pulse REPEAT_CYCLES cycles after o_long_stb.
REQ-025 SHALL in HELD with i_repeat_en=0 hold counter at 0 and emit no repeat; re-enabling restarts a full REPEAT_CYCLES period.
REQ-026 SHALL on accepted release from PRESSED or HELD go RELEASED, clear hold counter, suppress any long/repeat strobe in that cycle.
REQ-027 SHALL treat channels fully independently; simultaneous events on multiple channels all strobe in the same cycle.
REQ-028 SHALL never assert o_press_stb and o_release_stb for one channel in the same cycle.

Reset
REQ-029 SHALL on i_rst_n low immediately clear o_level, all strobes, o_any_stb, counters; FSMs to RELEASED.
REQ-030 SHALL reset synchronizer flops to the released pin level (0 if ACTIVE_HIGH=1, 1 otherwise) so deassertion with button idle yields no event.
REQ-031 SHALL, if button is held across reset deassertion, debounce it as a fresh press (press strobe after DB_CYCLES+2 edges).
REQ-032 SHALL deassert reset synchronously to i_clk by the integrating top level; block needs no internal reset synchronizer.

Verification (defaults unless stated)
REQ-033 SHALL verify: ch0 pressed clean -> o_level[0] rises and o_press_stb[0] pulses 1 cycle at edge 18; release -> o_release_stb[0] at edge 18 after release.
REQ-034 SHALL verify: ch1 15-cycle glitch then released -> no strobes, o_level[1]=0 throughout.
REQ-035 SHALL verify: ch2 held 1600 cycles, i_repeat_en[2]=1 -> o_long_stb 1000 after press strobe, repeats at +250, +500; release produces no further repeat.
REQ-036 SHALL verify: ACTIVE_HIGH=0, N_CH=3, all pins driven 0 simultaneously -> three press strobes same cycle, o_any_stb=1 one cycle.
REQ-037 SHALL verify: i_rst_n low during HELD -> all outputs 0 asynchronously; button still held after release of reset -> new press strobe at edge 18, long after 1000 more.
